ram_arbiter: RTL

Round-robin arbiter and sequencer that shares the single-port, 8x8 synchronous RAM between two requesters.
- Each requester issues reads or writes over a req/gnt handshake. The arbiter drives the RAM's address, write-data, write-enable and reset pins from registers, and returns registered read data to the requester that issued the read.
- A clear command sequences a whole-memory reset through the RAM's synchronous reset pin and blocks requesters while it runs.
- The block sits between the two RAM clients and the RAM instance.

---
 rtl/ram_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and clear sequencer sharing one single-port synchronous RAM between two requesters.
// Define RAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for requester 0.
module ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    input  logic              i_clr,
    output logic              o_clr_done,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    output logic              o_ram_rst,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic              prefer0;
    logic              arb_en;
    logic              xfer;
    logic              xfer_we;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;
    logic [1:0]        rd_pend;

    // Grants are combinational so a requester sees the transfer in the same cycle it asks.
    assign arb_en = (state == ST_RUN) && !i_clr;
    assign o_gnt0 = arb_en && i_req0 && (!i_req1 || prefer0);
    assign o_gnt1 = arb_en && i_req1 && !(i_req0 && prefer0);

    assign xfer       = o_gnt0 || o_gnt1;
    assign xfer_we    = o_gnt1 ? i_we1    : i_we0;
    assign xfer_addr  = o_gnt1 ? i_addr1  : i_addr0;
    assign xfer_wdata = o_gnt1 ? i_wdata1 : i_wdata0;

    // RAM output is registered inside the RAM, so read data is only qualified here.
    assign o_rdata0 = i_ram_rdata;
    assign o_rdata1 = i_ram_rdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign prefer0 = 1'b1;
`else
    logic last_gnt1;

    // Starts as if requester 1 went last, so requester 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt1 <= 1'b1;
        end else if (o_gnt0) begin
            last_gnt1 <= 1'b0;
        end else if (o_gnt1) begin
            last_gnt1 <= 1'b1;
        end
    end

    assign prefer0 = last_gnt1;
`endif

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_RUN;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
            o_ram_we    <= 1'b0;
            o_ram_rst   <= 1'b0;
            rd_pend     <= 2'b00;
            o_rvalid0   <= 1'b0;
            o_rvalid1   <= 1'b0;
            o_clr_done  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_ram_we   <= xfer && xfer_we;
            if (xfer) begin
                o_ram_addr  <= xfer_addr;
                o_ram_wdata <= xfer_wdata;
            end

            // Two stages: command on the RAM pins, then the RAM's own output register.
            rd_pend   <= {o_gnt1 && !i_we1, o_gnt0 && !i_we0};
            o_rvalid0 <= rd_pend[0];
            o_rvalid1 <= rd_pend[1];

            o_ram_rst  <= 1'b0;
            o_clr_done <= 1'b0;
            o_busy     <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (i_clr) begin
                        state     <= ST_CLEAR;
                        o_ram_rst <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_DONE;
                    o_clr_done <= 1'b1;
                    o_busy     <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
